hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard bus: decoding instruction, pipeline
// advance conditions, forwarding selects and the load-use stall.
interface hazard_scoreboard_if #(
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned REG_W     = 5
);
  localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

  logic             IN_VALID;
  logic [REG_W-1:0] RS1_SEL;
  logic [REG_W-1:0] RS2_SEL;
  logic [REG_W-1:0] RD_IN;
  logic [1:0]       TYPE_IN;
  logic             DATA_CACHE_READY;
  logic             INS_CACHE_READY;
  logic             EXSTAGE_STALLED;
  logic             FLUSH;
  logic [SEL_W-1:0] MUX1_SELECT;
  logic [SEL_W-1:0] MUX2_SELECT;
  logic [1:0]       RS1_TYPE;
  logic [1:0]       RS2_TYPE;
  logic             HAZARD_STALL;
  logic [31:0]      STALL_COUNT;

  modport slave (
    input  IN_VALID, RS1_SEL, RS2_SEL, RD_IN, TYPE_IN,
           DATA_CACHE_READY, INS_CACHE_READY, EXSTAGE_STALLED, FLUSH,
    output MUX1_SELECT, MUX2_SELECT, RS1_TYPE, RS2_TYPE,
           HAZARD_STALL, STALL_COUNT
  );

  modport master (
    output IN_VALID, RS1_SEL, RS2_SEL, RD_IN, TYPE_IN,
           DATA_CACHE_READY, INS_CACHE_READY, EXSTAGE_STALLED, FLUSH,
    input  MUX1_SELECT, MUX2_SELECT, RS1_TYPE, RS2_TYPE,
           HAZARD_STALL, STALL_COUNT
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Operand hazard scoreboard for the decode stage. Tracks {valid, rd, type}
// of every instruction in the FWD_DEPTH forwarding stages, picks the
// youngest producer per source operand and raises a load-use stall when
// that producer cannot forward yet.
// Optional feature macro: SCOREBOARD_LOAD_FWD_EN -- when defined, loads
// forward from stage LOAD_LAT onward; when undefined, a consumer of an
// in-flight load waits until it has retired to the register file.
module hazard_scoreboard #(
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned REG_W     = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  hazard_scoreboard_if.slave    bus
);
  localparam int unsigned SEL_W     = $clog2(FWD_DEPTH + 1);
  localparam logic [1:0]  TYPE_IDLE = 2'd0;
  localparam logic [1:0]  TYPE_LOAD = 2'd2;

  // Elaboration-time guard on the configuration range.
  if (FWD_DEPTH < 1 || FWD_DEPTH > 7 || LOAD_LAT < 1 || LOAD_LAT > FWD_DEPTH) begin : g_bad_cfg
    $error("hazard_scoreboard: FWD_DEPTH must be 1..7 and LOAD_LAT 1..FWD_DEPTH");
  end

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [1:0]       typ;
  } entry_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [1:0]       typ;
    logic             pend;
  } fwd_t;

  entry_t      ent [1:FWD_DEPTH];
  fwd_t        fwd1;
  fwd_t        fwd2;
  logic        stall;
  logic        advance;
  logic        issue;
  logic [31:0] stall_count;

  // Youngest matching producer for one operand; pend when it cannot forward yet.
  function automatic fwd_t lookup(input logic [REG_W-1:0] rs);
    fwd_t r;
    logic hit;
    logic rdy;
    r   = '0;
    hit = 1'b0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
`ifdef SCOREBOARD_LOAD_FWD_EN
      rdy = (ent[k].typ != TYPE_LOAD) || (k >= int'(LOAD_LAT));
`else
      rdy = (ent[k].typ != TYPE_LOAD);
`endif
      if (!hit && ent[k].valid && ent[k].typ != TYPE_IDLE &&
          ent[k].rd == rs && rs != '0) begin
        hit = 1'b1;
        if (rdy) begin
          r.sel = SEL_W'(k);
          r.typ = ent[k].typ;
        end else begin
          r.pend = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Combinational operand lookup, stall and pipeline-advance decision.
  always_comb begin
    fwd1    = lookup(bus.RS1_SEL);
    fwd2    = lookup(bus.RS2_SEL);
    stall   = bus.IN_VALID & (fwd1.pend | fwd2.pend);
    advance = bus.DATA_CACHE_READY & bus.INS_CACHE_READY & ~bus.EXSTAGE_STALLED;
    issue   = advance & bus.IN_VALID & ~stall & ~bus.FLUSH;
  end

  assign bus.MUX1_SELECT  = fwd1.sel;
  assign bus.MUX2_SELECT  = fwd2.sel;
  assign bus.RS1_TYPE     = fwd1.typ;
  assign bus.RS2_TYPE     = fwd2.typ;
  assign bus.HAZARD_STALL = stall;
  assign bus.STALL_COUNT  = stall_count;

  // In-flight window: shift one stage per advance, bubble when nothing issues.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
        ent[k] <= '0;
      end
    end else if (advance) begin
      for (int k = int'(FWD_DEPTH); k >= 2; k--) begin
        ent[k] <= ent[k-1];
      end
      ent[1] <= issue ? entry_t'{valid: 1'b1, rd: bus.RD_IN, typ: bus.TYPE_IN} : '0;
    end
  end

  // Saturating count of stalled decode cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= '0;
    end else if (stall && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, all compared against a queue-based model of the window.
module tb_hazard_scoreboard;
  localparam int unsigned FWD_DEPTH = 3;
  localparam int unsigned LOAD_LAT  = 2;
  localparam int unsigned REG_W     = 5;
`ifdef SCOREBOARD_LOAD_FWD_EN
  localparam bit LOAD_FWD = 1'b1;
`else
  localparam bit LOAD_FWD = 1'b0;
`endif

  typedef struct {
    bit v;
    int rd;
    int typ;
  } mentry_t;

  logic CLK;
  logic RST;
  hazard_scoreboard_if #(.FWD_DEPTH(FWD_DEPTH), .REG_W(REG_W)) bus ();

  hazard_scoreboard #(
    .FWD_DEPTH(FWD_DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .REG_W    (REG_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  mentry_t     win[$];
  logic [31:0] m_count;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer at window position i is stage i+1; first match is the youngest.
  function automatic void lookup(input int rs, output int sel, output int typ, output bit pend);
    sel = 0; typ = 0; pend = 1'b0;
    for (int i = 0; i < win.size(); i++) begin
      if (win[i].v && win[i].typ != 0 && win[i].rd == rs && rs != 0) begin
        if (win[i].typ != 2 || (LOAD_FWD && (i + 1) >= int'(LOAD_LAT))) begin
          sel = i + 1;
          typ = win[i].typ;
        end else begin
          pend = 1'b1;
        end
        return;
      end
    end
  endfunction

  function automatic bit exp_stall();
    int s, t;
    bit p1, p2;
    lookup(int'(bus.RS1_SEL), s, t, p1);
    lookup(int'(bus.RS2_SEL), s, t, p2);
    return bus.IN_VALID && (p1 || p2);
  endfunction

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < int'(FWD_DEPTH); i++) win.push_back('{v: 1'b0, rd: 0, typ: 0});
    m_count = 32'd0;
  endtask

  task automatic model_clock();
    bit st, adv, iss;
    if (RST) begin
      model_reset();
      return;
    end
    st  = exp_stall();
    if (st && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    adv = bus.DATA_CACHE_READY && bus.INS_CACHE_READY && !bus.EXSTAGE_STALLED;
    iss = adv && bus.IN_VALID && !st && !bus.FLUSH;
    if (adv) begin
      if (iss) win.push_front('{v: 1'b1, rd: int'(bus.RD_IN), typ: int'(bus.TYPE_IN)});
      else     win.push_front('{v: 1'b0, rd: 0, typ: 0});
      void'(win.pop_back());
    end
  endtask

  task automatic drive(input bit valid, input int rs1, input int rs2, input int rd,
                       input int typ, input bit exst, input bit flush);
    bus.IN_VALID         = valid;
    bus.RS1_SEL          = REG_W'(rs1);
    bus.RS2_SEL          = REG_W'(rs2);
    bus.RD_IN            = REG_W'(rd);
    bus.TYPE_IN          = 2'(typ);
    bus.DATA_CACHE_READY = 1'b1;
    bus.INS_CACHE_READY  = 1'b1;
    bus.EXSTAGE_STALLED  = exst;
    bus.FLUSH            = flush;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance both.
  task automatic cyc(input bit do_chk);
    int s1, s2, t1, t2;
    bit p1, p2;
    @(negedge CLK);
    if (do_chk) begin
      lookup(int'(bus.RS1_SEL), s1, t1, p1);
      lookup(int'(bus.RS2_SEL), s2, t2, p2);
      chk("mux1", 32'(bus.MUX1_SELECT), 32'(s1));
      chk("mux2", 32'(bus.MUX2_SELECT), 32'(s2));
      chk("type1", 32'(bus.RS1_TYPE), 32'(t1));
      chk("type2", 32'(bus.RS2_TYPE), 32'(t2));
      chk("stall", 32'(bus.HAZARD_STALL), 32'(bus.IN_VALID && (p1 || p2)));
      chk("count", bus.STALL_COUNT, m_count);
    end
    @(posedge CLK);
    model_clock();
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    cyc(0);
    cyc(0);
    RST = 1'b0;

    // Reset state.
    #1;
    chk("rst_mux1", 32'(bus.MUX1_SELECT), 32'd0);
    chk("rst_stall", 32'(bus.HAZARD_STALL), 32'd0);
    chk("rst_count", bus.STALL_COUNT, 32'd0);

    // ALU producer forwards from stage 1.
    drive(1, 0, 0, 5, 1, 0, 0); cyc(1);
    drive(1, 5, 0, 0, 0, 0, 0); #1;
    chk("alu_fwd_sel", 32'(bus.MUX1_SELECT), 32'd1);
    chk("alu_fwd_type", 32'(bus.RS1_TYPE), 32'd1);
    chk("alu_fwd_stall", 32'(bus.HAZARD_STALL), 32'd0);
    cyc(1);

    // Load-use: stall until the load can be taken.
    drive(1, 0, 0, 7, 2, 0, 0); cyc(1);
    drive(1, 0, 7, 0, 0, 0, 0); #1;
    chk("load_stall_first", 32'(bus.HAZARD_STALL), 32'd1);
    cyc(1);
`ifdef SCOREBOARD_LOAD_FWD_EN
    #1;
    chk("load_fwd_sel", 32'(bus.MUX2_SELECT), 32'd2);
    chk("load_fwd_type", 32'(bus.RS2_TYPE), 32'd2);
    chk("load_fwd_count", bus.STALL_COUNT, 32'd1);
    cyc(1);
`else
    cyc(1);
    #1;
    chk("load_stall_third", 32'(bus.HAZARD_STALL), 32'd1);
    cyc(1);
    #1;
    chk("load_retired_sel", 32'(bus.MUX2_SELECT), 32'd0);
    chk("load_retired_stall", 32'(bus.HAZARD_STALL), 32'd0);
    chk("load_retired_count", bus.STALL_COUNT, 32'd3);
    cyc(1);
`endif

    // Two writers of x3: the younger one wins.
    drive(1, 0, 0, 3, 1, 0, 0); cyc(1);
    drive(1, 0, 0, 3, 3, 0, 0); cyc(1);
    drive(1, 3, 0, 0, 0, 0, 0); #1;
    chk("youngest_sel", 32'(bus.MUX1_SELECT), 32'd1);
    chk("youngest_type", 32'(bus.RS1_TYPE), 32'd3);
    cyc(1);

    // x0 is never forwarded.
    drive(1, 0, 0, 0, 1, 0, 0); cyc(1);
    drive(1, 0, 0, 0, 0, 0, 0); #1;
    chk("x0_sel", 32'(bus.MUX1_SELECT), 32'd0);
    chk("x0_stall", 32'(bus.HAZARD_STALL), 32'd0);
    cyc(1);

    // EX busy freezes the window; then a flush with advance inserts a bubble.
    drive(1, 0, 0, 9, 1, 0, 0); cyc(1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 9, 0, 0, 0, 1, 0); #1;
      chk("frozen_sel", 32'(bus.MUX1_SELECT), 32'd1);
      cyc(1);
    end
    drive(1, 9, 0, 11, 1, 1, 1); cyc(1);
    drive(1, 9, 0, 11, 1, 0, 1); cyc(1);
    drive(1, 9, 11, 0, 0, 0, 0); #1;
    chk("flush_old_sel", 32'(bus.MUX1_SELECT), 32'd2);
    chk("flush_bubble_sel", 32'(bus.MUX2_SELECT), 32'd0);
    cyc(1);

    // Reset while a load-use stall is pending.
    drive(1, 0, 0, 4, 2, 0, 0); cyc(1);
    drive(1, 4, 0, 0, 0, 0, 0); #1;
    chk("pre_rst_stall", 32'(bus.HAZARD_STALL), 32'd1);
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
    #1;
    chk("post_rst_stall", 32'(bus.HAZARD_STALL), 32'd0);
    chk("post_rst_sel", 32'(bus.MUX1_SELECT), 32'd0);
    chk("post_rst_count", bus.STALL_COUNT, 32'd0);
    cyc(1);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      bus.IN_VALID         = ($urandom_range(0, 4) != 0);
      bus.RS1_SEL          = REG_W'($urandom_range(0, 7));
      bus.RS2_SEL          = REG_W'($urandom_range(0, 7));
      bus.RD_IN            = REG_W'($urandom_range(0, 7));
      bus.TYPE_IN          = 2'($urandom_range(0, 3));
      bus.DATA_CACHE_READY = ($urandom_range(0, 9) != 0);
      bus.INS_CACHE_READY  = ($urandom_range(0, 9) != 0);
      bus.EXSTAGE_STALLED  = ($urandom_range(0, 7) == 0);
      bus.FLUSH            = ($urandom_range(0, 9) == 0);
      RST                  = ($urandom_range(0, 79) == 0);
      cyc(1);
    end
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
